// File: rtl/ttc_trigger_fifo_reader.sv
// ttc_trigger_fifo_reader: pops one 128-bit trigger word per trigger, unpacks it, checks it and requests a readout. Ports: clk/reset, reset_trig_num, FIFO handshake (fifo_valid/fifo_data/fifo_ready), command-manager handshake (readout_req/ack/done), unpacked rd_* fields, one-hot state, words_read counter, error_trig_num/format/timeout flags.
module ttc_trigger_fifo_reader #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reset_trig_num,
  input  logic         fifo_valid,
  input  logic [127:0] fifo_data,
  output logic         fifo_ready,
  output logic         readout_req,
  input  logic         readout_ack,
  input  logic         readout_done,
  output logic [43:0]  rd_trig_timestamp,
  output logic [23:0]  rd_trig_num,
  output logic [23:0]  rd_event_cnt,
  output logic [4:0]   rd_trig_type,
  output logic         rd_empty_event,
  output logic [3:0]   rd_xadc_alarms,
  output logic         rd_empty_payload,
  output logic [4:0]   state,
  output logic [31:0]  words_read,
  output logic         error_trig_num,
  output logic         error_format,
  output logic         error_timeout
);
  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    CHECK     = 5'b00010,
    REQUEST   = 5'b00100,
    WAIT_DONE = 5'b01000,
    ERROR     = 5'b10000
  } state_t;
  state_t cur, nxt;
  logic [23:0] exp_trig_num;
  logic [31:0] to_cnt;
  logic fmt_bad;
  logic xfer;
  logic to_hit;
  assign state  = cur;
  assign xfer   = fifo_valid & fifo_ready;
  assign to_hit = (TIMEOUT_CYCLES != 32'd0) && (to_cnt + 32'd1 == TIMEOUT_CYCLES);
  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:      nxt = xfer ? CHECK : IDLE;
      CHECK:     nxt = fmt_bad ? ERROR : REQUEST;
      REQUEST:   nxt = readout_ack ? (readout_done ? IDLE : WAIT_DONE) : REQUEST;
      WAIT_DONE: nxt = readout_done ? IDLE : (to_hit ? ERROR : WAIT_DONE);
      ERROR:     nxt = ERROR;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur               <= IDLE;
      fifo_ready        <= 1'b0;
      readout_req       <= 1'b0;
      rd_trig_timestamp <= '0;
      rd_trig_num       <= '0;
      rd_event_cnt      <= '0;
      rd_trig_type      <= '0;
      rd_empty_event    <= 1'b0;
      rd_xadc_alarms    <= '0;
      rd_empty_payload  <= 1'b0;
      fmt_bad           <= 1'b0;
      words_read        <= '0;
      error_trig_num    <= 1'b0;
      error_format      <= 1'b0;
      error_timeout     <= 1'b0;
      exp_trig_num      <= 24'd1;
      to_cnt            <= '0;
    end else begin
      cur         <= nxt;
      fifo_ready  <= nxt == IDLE;
      readout_req <= nxt == REQUEST;
      if (xfer) begin
        rd_trig_timestamp <= fifo_data[43:0];
        rd_trig_num       <= fifo_data[67:44];
        rd_event_cnt      <= fifo_data[91:68];
        rd_trig_type      <= fifo_data[96:92];
        rd_empty_event    <= fifo_data[97];
        rd_xadc_alarms    <= fifo_data[101:98];
        rd_empty_payload  <= fifo_data[102];
        fmt_bad           <= |fifo_data[127:103];
        words_read        <= words_read + 32'd1;
      end
      if (cur == CHECK && fmt_bad) error_format <= 1'b1;
      if (cur == CHECK && !fmt_bad && rd_trig_num != exp_trig_num) error_trig_num <= 1'b1;
      // Match or resync both leave the expectation one past the word just checked.
      exp_trig_num  <= reset_trig_num ? 24'd1 : (cur == CHECK && !fmt_bad) ? rd_trig_num + 24'd1 : exp_trig_num;
      to_cnt        <= (cur == WAIT_DONE && !readout_done) ? to_cnt + 32'd1 : '0;
      error_timeout <= error_timeout | (cur == WAIT_DONE && !readout_done && to_hit);
    end
  end
endmodule

// File: tb/tb_ttc_trigger_fifo_reader.sv
// tb_ttc_trigger_fifo_reader: scoreboard bench for ttc_trigger_fifo_reader (timeout 100 instance plus timeout-disabled instance).
module tb_ttc_trigger_fifo_reader;
  logic clk = 1'b0;
  logic reset, reset_trig_num, fifo_valid, readout_ack, readout_done;
  logic [127:0] fifo_data;
  logic fifo_ready, readout_req, rd_empty_event, rd_empty_payload;
  logic [43:0] rd_trig_timestamp;
  logic [23:0] rd_trig_num, rd_event_cnt;
  logic [4:0] rd_trig_type, state;
  logic [3:0] rd_xadc_alarms;
  logic [31:0] words_read;
  logic error_trig_num, error_format, error_timeout;
  logic fifo_ready_b, readout_req_b, rd_empty_event_b, rd_empty_payload_b;
  logic [43:0] rd_trig_timestamp_b;
  logic [23:0] rd_trig_num_b, rd_event_cnt_b;
  logic [4:0] rd_trig_type_b, state_b;
  logic [3:0] rd_xadc_alarms_b;
  logic [31:0] words_read_b;
  logic error_trig_num_b, error_format_b, error_timeout_b;
  int vectors = 0;
  int miscompares = 0;
  logic [127:0] sb[$];
  localparam logic [4:0] S_IDLE = 5'b00001, S_WAIT = 5'b01000, S_ERR = 5'b10000;

  ttc_trigger_fifo_reader #(.TIMEOUT_CYCLES(32'd100)) dut_a (
    .clk(clk), .reset(reset), .reset_trig_num(reset_trig_num), .fifo_valid(fifo_valid),
    .fifo_data(fifo_data), .fifo_ready(fifo_ready), .readout_req(readout_req),
    .readout_ack(readout_ack), .readout_done(readout_done),
    .rd_trig_timestamp(rd_trig_timestamp), .rd_trig_num(rd_trig_num), .rd_event_cnt(rd_event_cnt),
    .rd_trig_type(rd_trig_type), .rd_empty_event(rd_empty_event), .rd_xadc_alarms(rd_xadc_alarms),
    .rd_empty_payload(rd_empty_payload), .state(state), .words_read(words_read),
    .error_trig_num(error_trig_num), .error_format(error_format), .error_timeout(error_timeout));

  ttc_trigger_fifo_reader #(.TIMEOUT_CYCLES(32'd0)) dut_b (
    .clk(clk), .reset(reset), .reset_trig_num(reset_trig_num), .fifo_valid(fifo_valid),
    .fifo_data(fifo_data), .fifo_ready(fifo_ready_b), .readout_req(readout_req_b),
    .readout_ack(readout_ack), .readout_done(readout_done),
    .rd_trig_timestamp(rd_trig_timestamp_b), .rd_trig_num(rd_trig_num_b), .rd_event_cnt(rd_event_cnt_b),
    .rd_trig_type(rd_trig_type_b), .rd_empty_event(rd_empty_event_b), .rd_xadc_alarms(rd_xadc_alarms_b),
    .rd_empty_payload(rd_empty_payload_b), .state(state_b), .words_read(words_read_b),
    .error_trig_num(error_trig_num_b), .error_format(error_format_b), .error_timeout(error_timeout_b));

  always #12 clk = ~clk;

  function automatic logic [127:0] mk(input logic [23:0] num, input logic [4:0] typ, input logic empty);
    logic [127:0] w;
    w = '0;
    w[31:0]   = $urandom();
    w[43:32]  = 12'($urandom());
    w[67:44]  = num;
    w[91:68]  = 24'($urandom());
    w[96:92]  = typ;
    w[97]     = empty;
    w[101:98] = 4'($urandom());
    w[102]    = 1'($urandom());
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    reset_trig_num = 1'b0; fifo_valid = 1'b0; fifo_data = '0; readout_ack = 1'b0; readout_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic push_word(input logic [127:0] w, input bit expect_req);
    int n;
    n = 0;
    while (!fifo_ready && n < 50) begin tick(); n++; end
    vectors++;
    if (!fifo_ready) begin
      miscompares++;
      $display("FAIL fifo_ready_wait: fifo_ready=%b required 1 within 50 cycles", fifo_ready);
    end else begin
      fifo_valid = 1'b1; fifo_data = w;
      tick();
      fifo_valid = 1'b0; fifo_data = '0;
      if (expect_req) sb.push_back(w);
    end
  endtask

  task automatic serve(input int lat, input int ack_dly, input bit same, input int done_dly);
    logic [127:0] w;
    logic [102:0] got;
    int n;
    n = 0;
    while (!readout_req && n < 50) begin tick(); n++; end
    vectors++;
    if (!readout_req || n != lat) begin
      miscompares++;
      $display("FAIL req_latency: readout_req=%b after %0d cycles, required 1 after %0d", readout_req, n, lat);
    end
    if (readout_req) begin
      w = sb.size() != 0 ? sb.pop_front() : '0;
      got = {rd_empty_payload, rd_xadc_alarms, rd_empty_event, rd_trig_type, rd_event_cnt, rd_trig_num, rd_trig_timestamp};
      vectors++;
      if (got !== w[102:0]) begin
        miscompares++;
        $display("FAIL req_fields: got %h required %h", got, w[102:0]);
      end
      repeat (ack_dly) tick();
      got = {rd_empty_payload, rd_xadc_alarms, rd_empty_event, rd_trig_type, rd_event_cnt, rd_trig_num, rd_trig_timestamp};
      vectors++;
      if (got !== w[102:0] || readout_req !== 1'b1) begin
        miscompares++;
        $display("FAIL req_hold: fields %h req %b required %h req 1", got, readout_req, w[102:0]);
      end
      readout_ack = 1'b1; readout_done = same;
      tick();
      readout_ack = 1'b0; readout_done = 1'b0;
      vectors++;
      if (readout_req !== 1'b0) begin
        miscompares++;
        $display("FAIL req_drop: readout_req=%b required 0", readout_req);
      end
      if (!same) begin
        repeat (done_dly - 1) tick();
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
      end
      vectors++;
      if (state !== S_IDLE) begin
        miscompares++;
        $display("FAIL done_idle: state=%b required %b", state, S_IDLE);
      end
    end
  endtask

  task automatic chk_exp(input string nm, input logic [23:0] e, input logic et);
    vectors++;
    if (dut_a.exp_trig_num !== e || error_trig_num !== et) begin
      miscompares++;
      $display("FAIL %s: expected_num=%h err=%b required %h err %b", nm, dut_a.exp_trig_num, error_trig_num, e, et);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({state, fifo_ready, readout_req, words_read, error_trig_num, error_format, error_timeout, rd_trig_num, rd_trig_timestamp} !==
        {S_IDLE, 1'b0, 1'b0, 32'd0, 3'b000, 24'd0, 44'd0}) begin
      miscompares++;
      $display("FAIL reset_values: state=%b ready=%b req=%b words=%0d errs=%b%b%b num=%h", state, fifo_ready, readout_req,
               words_read, error_trig_num, error_format, error_timeout, rd_trig_num);
    end
    tick();
    vectors++;
    if (fifo_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: fifo_ready=%b required 1", fifo_ready);
    end
    push_word(mk(24'd1, 5'd2, 1'b0), 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (state !== S_IDLE || readout_req !== 1'b0 || words_read !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid: state=%b req=%b words=%0d required %b 0 0", state, readout_req, words_read, S_IDLE);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      push_word(mk(24'(i), 5'd3, 1'b0), 1'b1);
      serve(1, 2, 1'b0, 5);
    end
    vectors++;
    if (words_read !== 32'd3 || error_trig_num !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL seq_summary: words=%0d err=%b pending=%0d required 3 0 0", words_read, error_trig_num, sb.size());
    end
  endtask

  task automatic test_discontinuity();
    int nums[4] = '{1, 2, 5, 6};
    do_reset();
    foreach (nums[i]) begin
      push_word(mk(24'(nums[i]), 5'd4, 1'b0), 1'b1);
      serve(1, 2, 1'b0, 3);
      chk_exp("discont", 24'(nums[i] + 1), nums[i] >= 5);
    end
    vectors++;
    if (words_read !== 32'd4) begin
      miscompares++;
      $display("FAIL discont_words: words=%0d required 4", words_read);
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    push_word(mk(24'd1, 5'd1, 1'b0), 1'b1);
    serve(1, 1, 1'b1, 0);
    push_word(mk(24'd2, 5'd1, 1'b0), 1'b1);
    serve(1, 0, 1'b1, 0);
    reset_trig_num = 1'b1; tick(); reset_trig_num = 1'b0;
    push_word(mk(24'd1, 5'd1, 1'b0), 1'b1);
    serve(1, 2, 1'b0, 2);
    chk_exp("trig_num_reset", 24'd2, 1'b0);
    push_word(mk(24'hFFFFFF, 5'd1, 1'b0), 1'b1);
    serve(1, 2, 1'b0, 2);
    chk_exp("wrap_ffffff", 24'd0, 1'b1);
    push_word(mk(24'd0, 5'd1, 1'b0), 1'b1);
    serve(1, 2, 1'b0, 2);
    chk_exp("wrap_zero", 24'd1, 1'b1);
    push_word(mk(24'd7, 5'd1, 1'b0), 1'b1);
    reset_trig_num = 1'b1; tick(); reset_trig_num = 1'b0;
    serve(0, 2, 1'b0, 2);
    chk_exp("trig_reset_priority", 24'd1, 1'b1);
  endtask

  task automatic test_empty_event();
    do_reset();
    push_word(mk(24'd1, 5'b00001, 1'b1), 1'b1);
    serve(1, 2, 1'b0, 5);
    vectors++;
    if (rd_empty_event !== 1'b1 || rd_trig_type !== 5'd1 || error_trig_num !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_event: empty=%b type=%h err=%b required 1 01 0", rd_empty_event, rd_trig_type, error_trig_num);
    end
  endtask

  task automatic test_format();
    logic [127:0] w;
    do_reset();
    w = mk(24'd1, 5'd2, 1'b0);
    w[110] = 1'b1;
    push_word(w, 1'b0);
    tick();
    vectors++;
    if (state !== S_ERR || error_format !== 1'b1) begin
      miscompares++;
      $display("FAIL format_error: state=%b err_fmt=%b required %b 1", state, error_format, S_ERR);
    end
    fifo_valid = 1'b1; fifo_data = mk(24'd2, 5'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (fifo_ready !== 1'b0 || readout_req !== 1'b0 || state !== S_ERR) begin
        miscompares++;
        $display("FAIL format_hold: ready=%b req=%b state=%b required 0 0 %b", fifo_ready, readout_req, state, S_ERR);
      end
    end
    fifo_valid = 1'b0; fifo_data = '0;
    vectors++;
    if (words_read !== 32'd1 || error_trig_num !== 1'b0) begin
      miscompares++;
      $display("FAIL format_words: words=%0d err_num=%b required 1 0", words_read, error_trig_num);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    push_word(mk(24'd1, 5'd6, 1'b0), 1'b1);
    n = 0;
    while (!readout_req && n < 50) begin tick(); n++; end
    readout_ack = 1'b1; tick(); readout_ack = 1'b0;
    n = 0;
    while (!error_timeout && n < 300) begin tick(); n++; end
    vectors++;
    if (error_timeout !== 1'b1 || n != 100) begin
      miscompares++;
      $display("FAIL timeout_cycles: err_timeout=%b after %0d cycles, required 1 after 100", error_timeout, n);
    end
    repeat (20) tick();
    vectors++;
    if (state !== S_ERR || fifo_ready !== 1'b0 || readout_req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_hold: state=%b ready=%b req=%b required %b 0 0", state, fifo_ready, readout_req, S_ERR);
    end
    repeat (10000 - 120) tick();
    vectors++;
    if (error_timeout_b !== 1'b0 || state_b !== S_WAIT) begin
      miscompares++;
      $display("FAIL no_timeout: err_timeout=%b state=%b required 0 %b", error_timeout_b, state_b, S_WAIT);
    end
    readout_done = 1'b1; tick(); readout_done = 1'b0;
    vectors++;
    if (state_b !== S_IDLE || state !== S_ERR) begin
      miscompares++;
      $display("FAIL late_done: state_b=%b state=%b required %b %b", state_b, state, S_IDLE, S_ERR);
    end
    do_reset();
    vectors++;
    if (state !== S_IDLE || error_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_reset: state=%b err_timeout=%b required %b 0", state, error_timeout, S_IDLE);
    end
  endtask

  initial begin
    reset = 1'b1; reset_trig_num = 1'b0; fifo_valid = 1'b0; fifo_data = '0;
    readout_ack = 1'b0; readout_done = 1'b0;
    test_reset();
    test_sequence();
    test_discontinuity();
    test_boundaries();
    test_empty_event();
    test_format();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ttc_trigger_fifo_reader.md
Name: ttc_trigger_fifo_reader

Overview:
- Consumer end of the TTC Trigger FIFO: pops one 128-bit trigger-info word per trigger, unpacks it and checks it.
- Presents the unpacked fields to the command manager as a held readout request, then waits for completion.
- Sits between the TTC Trigger FIFO output and the command manager, in the 40 MHz TTC clock domain.
- Flags trigger-number discontinuities, malformed words and readout timeouts.

Parameters:
- TIMEOUT_CYCLES, 32'd0: max cycles in WAIT_DONE before a hard error; 0 disables the timeout.

Ports:
- clk  input  1  40 MHz TTC clock
- reset  input  1  synchronous, active-high reset
- reset_trig_num  input  1  TTC Channel B: expected trigger number returns to 1
- fifo_valid  input  1  FIFO output word valid
- fifo_data  input  128  FIFO output word
- fifo_ready  output  1  reader accepts word this cycle
- readout_req  output  1  request to command manager, held until ack
- readout_ack  input  1  command manager accepted the request
- readout_done  input  1  readout of current trigger completed
- rd_trig_timestamp  output  44  word[43:0]
- rd_trig_num  output  24  word[67:44]
- rd_event_cnt  output  24  word[91:68]
- rd_trig_type  output  5  word[96:92]
- rd_empty_event  output  1  word[97]
- rd_xadc_alarms  output  4  word[101:98]
- rd_empty_payload  output  1  word[102]
- state  output  5  one-hot FSM state
- words_read  output  32  count of words popped
- error_trig_num  output  1  sticky: trigger number discontinuity
- error_format  output  1  word[127:103] nonzero; hard error
- error_timeout  output  1  readout_done not received in time; hard error

Behaviour:
- Reset values: state = IDLE (5'b00001); fifo_ready 0; readout_req 0; all rd_* 0; words_read 0; all error flags 0; expected trig num = 1; timeout counter = 0.
- One-hot states: IDLE = bit 0, CHECK = 1, REQUEST = 2, WAIT_DONE = 3, ERROR = 4.
- fifo_ready is a registered output, 1 only while state = IDLE.
- Transfer occurs when fifo_valid & fifo_ready are both 1 in a cycle (cycle N). On transfer:
  - latch all rd_* fields at N+1;
  - words_read += 1 (32-bit wrap);
  - go to CHECK.
  - fifo_ready drops at N+1, so at most one word is popped per trigger.
- CHECK (one cycle):
  - If word[127:103] != 0: set error_format, go to ERROR.
  - Else if rd_trig_num != expected: set error_trig_num (sticky until reset), expected = rd_trig_num + 1 (resync), go to REQUEST.
  - Else: expected = expected + 1 (24-bit wrap, 0xFFFFFF -> 0), go to REQUEST.
- REQUEST: readout_req = 1, first seen at N+2. rd_* stable while readout_req = 1.
  - readout_ack & readout_done in the same cycle -> IDLE.
  - readout_ack alone -> WAIT_DONE.
  - Otherwise stay in REQUEST.
  - readout_req deasserts the cycle after the ack.
- Empty events (rd_empty_event = 1) and empty payloads are requested exactly like normal events; the command manager builds the reduced response.
- WAIT_DONE:
  - readout_done -> IDLE; timeout counter clears.
  - Otherwise the counter increments. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: set error_timeout, go to ERROR.
- readout_done is ignored in IDLE and CHECK.
- ERROR: terminal until reset. fifo_ready = 0, readout_req = 0, rd_* frozen.
- reset_trig_num: expected = 1 next cycle. It takes priority over the CHECK update in the same cycle; the CHECK comparison uses the pre-reset registered value. It does not affect words_read or the error flags.
- Reset mid-operation (any state): return to reset values next cycle. A request in flight is dropped without waiting for ack.

Test Plan:
- Seq 1: three words with trig_num 1, 2, 3, readout_ack 2 cycles after req, readout_done 5 cycles later -> three requests with matching fields; words_read = 3; error_trig_num = 0; readout_req first high 2 cycles after the transfer.
- Discontinuity: words trig_num 1, 2, 5, 6 -> error_trig_num set when 5 reaches CHECK and stays set; 6 raises no new mismatch (expected resynced to 6); all four requests still issued.
- Format: word with bit 110 set -> error_format = 1; state = ERROR; fifo_ready stays 0 with fifo_valid held high; no readout_req.
- Timeout: TIMEOUT_CYCLES = 100, ack but no done -> error_timeout exactly 100 cycles after entering WAIT_DONE; ERROR held until reset. With TIMEOUT_CYCLES = 0 the block waits 10000 cycles without error.
- Boundaries:
  - ack & done in the same cycle -> next state IDLE.
  - reset_trig_num pulsed, then word trig_num 1 -> no error.
  - trig_num 0xFFFFFF followed by 0 -> no error.
- Empty event: word with bit 97 = 1, trig_type 5'b00001 -> rd_empty_event = 1, rd_trig_type = 1, normal request/ack/done sequence.
